// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: datapath widths, ALU opcodes
// and the arbiter FSM state encoding.
package alu_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [OP_W-1:0] ALU_SLL = 4'd5;
    localparam logic [OP_W-1:0] ALU_SRL = 4'd6;
    localparam logic [OP_W-1:0] ALU_SLT = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU. Shifts move B by A[4:0]; SLT is unsigned;
// any opcode outside the defined set yields zero.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = b << a[4:0];
            ALU_SRL: result = b >> a[4:0];
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters;
// operands and results are registered, one operation in flight at a time.
module alu_arbiter #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4,
    parameter bit RR_INIT = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][DATA_W-1:0] req_a,
    input  logic [1:0][DATA_W-1:0] req_b,
    input  logic [1:0][OP_W-1:0]   req_op,
    output logic [1:0]             resp_valid,
    input  logic [1:0]             resp_ready,
    output logic [DATA_W-1:0]      resp_result,
    output logic                   resp_zero,
    output logic                   resp_illegal,
    output logic                   busy
);
    import alu_arbiter_pkg::*;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [1:0]          resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;
    logic                illegal_q, illegal_d;

    logic                pick;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;

    // On a tie the port that did not win last time gets the ALU.
    assign pick = (&req_valid) ? ~last_grant_q : req_valid[1];

    always_comb begin
        req_ready = 2'b00;
        if (state_q == IDLE && (|req_valid)) begin
            req_ready[pick] = 1'b1;
        end
    end

    alu_arbiter_alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        zero_d       = zero_q;
        illegal_d    = illegal_q;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = pick;
                    a_d     = req_a[pick];
                    b_d     = req_b[pick];
                    op_d    = req_op[pick];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d              = alu_result;
                zero_d                = alu_zero;
                illegal_d             = (op_q > OP_W'(ALU_SLT));
                resp_valid_d          = 2'b00;
                resp_valid_d[grant_q] = 1'b1;
                state_d               = RESP;
            end
            RESP: begin
                // Fairness pointer only advances once the response is consumed.
                if (resp_ready[grant_q]) begin
                    resp_valid_d = 2'b00;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= RR_INIT;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            resp_valid_q <= 2'b00;
            result_q     <= '0;
            zero_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            illegal_q    <= illegal_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_result  = result_q;
    assign resp_zero    = zero_q;
    assign resp_illegal = illegal_q;
    assign busy         = (state_q != IDLE);

endmodule
